// File: rtl/usensor_pkg.sv
// usensor_pkg: scheduler state encoding and default HC-SR04 timing at 50 MHz
package usensor_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;
  localparam int TRIG_CYCLES  = 500;
  localparam int ECHO_TIMEOUT = 1900000;
  localparam int GUARD_CYCLES = 3000000;
endpackage

// File: rtl/usensor_sync.sv
// usensor_sync: 2-flop synchronizer for the raw echo pins
module usensor_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/usensor_scheduler.sv
// usensor_scheduler: round-robin trigger/echo-width measurement over several HC-SR04 sensors
module usensor_scheduler
  import usensor_pkg::*;
#(
  parameter int NUM_SENSORS  = 4,
  parameter int TRIG_CYCLES  = usensor_pkg::TRIG_CYCLES,
  parameter int ECHO_TIMEOUT = usensor_pkg::ECHO_TIMEOUT,
  parameter int GUARD_CYCLES = usensor_pkg::GUARD_CYCLES,
  parameter int CNT_W        = 22
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_SENSORS-1:0]         sensor_mask,
  input  logic [NUM_SENSORS-1:0]         echo,
  output logic [NUM_SENSORS-1:0]         trig,
  output logic                           busy,
  output logic                           result_valid,
  output logic [$clog2(NUM_SENSORS)-1:0] result_id,
  output logic [CNT_W-1:0]               result_width,
  output logic                           result_timeout
);
  localparam int ID_W = $clog2(NUM_SENSORS);
  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ECHO_MAX   = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0] ECHO_LAST  = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, width, width_d, fire_w;
  logic [ID_W-1:0] sel, sel_d, last, last_d, first, after, nxt;
  logic has_after, fire, fire_to, echo_sel;
  logic [NUM_SENSORS-1:0] echo_s;
  usensor_sync #(.W(NUM_SENSORS)) u_sync (.clk(clk), .reset(reset), .d(echo), .q(echo_s));
  assign echo_sel = echo_s[sel];
  assign busy = state != IDLE;
  assign nxt = has_after ? after : first;
  // Lowest set bit above last-served wins, else wrap to the lowest set bit overall.
  always_comb begin
    first = '0;
    after = '0;
    has_after = 1'b0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (sensor_mask[i]) first = ID_W'(i);
      if (sensor_mask[i] && i > int'(last)) begin
        after = ID_W'(i);
        has_after = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt + 1'b1;
    width_d = width;
    sel_d = sel;
    last_d = last;
    fire = 1'b0;
    fire_to = 1'b0;
    fire_w = '0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        width_d = '0;
        if (enable && |sensor_mask) begin
          state_d = TRIG;
          sel_d = nxt;
        end
      end
      TRIG: if (cnt == TRIG_LAST) begin
        state_d = WAIT_RISE;
        cnt_d = '0;
      end
      WAIT_RISE: if (echo_sel) begin
        state_d = MEASURE;
        width_d = CNT_W'(1);
      end else if (cnt == ECHO_LAST) begin
        state_d = GUARD;
        cnt_d = '0;
        fire = 1'b1;
        fire_to = 1'b1;
      end
      MEASURE: if (!echo_sel) begin
        state_d = GUARD;
        cnt_d = '0;
        fire = 1'b1;
        fire_w = width;
      end else if (width == ECHO_LAST) begin
        state_d = GUARD;
        cnt_d = '0;
        fire = 1'b1;
        fire_to = 1'b1;
        fire_w = ECHO_MAX;
      end else width_d = width + 1'b1;
      GUARD: if (cnt == GUARD_LAST) begin
        state_d = IDLE;
        last_d = sel;
      end
      default: state_d = IDLE;
    endcase
  end
  // trig is registered from the next state so the sensor pins never see decode glitches.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      width <= '0;
      sel <= '0;
      last <= ID_W'(NUM_SENSORS - 1);
      trig <= '0;
      result_valid <= 1'b0;
      result_id <= '0;
      result_width <= '0;
      result_timeout <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      width <= width_d;
      sel <= sel_d;
      last <= last_d;
      trig <= (state_d == TRIG) ? NUM_SENSORS'(1) << sel_d : '0;
      result_valid <= fire;
      if (fire) begin
        result_id <= sel;
        result_width <= fire_w;
        result_timeout <= fire_to;
      end
    end
endmodule

// File: tb/tb_usensor_scheduler.sv
// tb_usensor_scheduler: randomized sensor-response bench against a round-robin/echo-width reference model
module tb_usensor_scheduler;
  localparam int N = 4, T_TRIG = 5, T_ECHO = 100, T_GUARD = 20, CW = 22;
  typedef struct {int id; int w; bit to; int due;} exp_t;
  logic clk = 0, reset = 0, enable = 0, busy, result_valid, result_timeout;
  logic [N-1:0] sensor_mask = '0, echo = '0, trig;
  logic [1:0] result_id;
  logic [CW-1:0] result_width;
  int n_checks = 0, n_errors = 0;
  exp_t q[$];
  int cyc = 0, res_cnt = 0, last_res_cyc = 0, model_last = N - 1, trig_len = 0, cur = 0, exp_id = 0;
  int dly[N], hi[N];
  logic [N-1:0] stuck = '0, noise = '0, prev_trig = '0, prev_mask = '0;
  logic prev_en = 0;
  bit rr_arm = 0, h_to = 0;
  int mode = 0, fix_d = 0, fix_w = 0, h_id = 0, h_w = 0;

  usensor_scheduler #(.NUM_SENSORS(N), .TRIG_CYCLES(T_TRIG), .ECHO_TIMEOUT(T_ECHO),
    .GUARD_CYCLES(T_GUARD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor_mask(sensor_mask), .echo(echo),
    .trig(trig), .busy(busy), .result_valid(result_valid), .result_id(result_id),
    .result_width(result_width), .result_timeout(result_timeout));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rr(logic [N-1:0] m, int last);
    for (int i = 1; i <= N; i++) if (m[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // Echo rises at raw offset d after trig falls; the 2-flop sync makes it visible in wait cycle d+3.
  task automatic on_fall();
    int d = 0, w = 0, rise, r;
    exp_t e;
    if (mode == 2) begin d = fix_d; w = fix_w; end
    else if (mode == 0) begin
      r = $urandom_range(0, 9);
      case (r)
        0: w = 0;
        1: begin d = 97; w = 5; end
        2: begin d = 98; w = 5; end
        3: begin d = $urandom_range(0, 10); w = 99; end
        4: begin d = $urandom_range(0, 10); w = 100; end
        5: begin d = $urandom_range(0, 10); w = $urandom_range(101, 110); end
        default: begin d = $urandom_range(0, 40); w = $urandom_range(1, 98); end
      endcase
    end
    rise = stuck[cur] ? 1 : d + 3;
    e.id = exp_id;
    if (!stuck[cur] && (w == 0 || rise > T_ECHO)) begin e.w = 0; e.to = 1; e.due = cyc + T_ECHO; end
    else if (stuck[cur] || w >= T_ECHO) begin e.w = T_ECHO; e.to = 1; e.due = cyc + rise + T_ECHO - 1; end
    else begin e.w = w; e.to = 0; e.due = cyc + rise + w; end
    q.push_back(e);
    dly[cur] = d;
    hi[cur] = w;
  endtask

  initial begin
    exp_t e;
    for (int k = 0; k < N; k++) begin dly[k] = 0; hi[k] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_trig = '0;
        echo = '0;
        continue;
      end
      check("trig_onehot", 64'($onehot0(trig)), 1);
      if (trig != 0) check("busy_in_trig", busy, 1);
      if (trig != 0 && prev_trig == 0) begin
        for (int k = 0; k < N; k++) if (trig[k]) cur = k;
        exp_id = rr(prev_mask, model_last);
        check("trig_id", cur, exp_id);
        check("trig_enable", prev_en, 1);
        if (rr_arm) check("guard_gap", cyc - last_res_cyc, T_GUARD + 1);
        model_last = exp_id;
        trig_len = 0;
      end
      if (trig != 0) trig_len++;
      if (trig == 0 && prev_trig != 0) begin
        check("trig_len", trig_len, T_TRIG);
        on_fall();
      end
      if (result_valid) begin
        res_cnt++;
        last_res_cyc = cyc;
        rr_arm = 1;
        if (q.size() == 0) check("res_spurious", 1, 0);
        else begin
          e = q.pop_front();
          check("res_id", result_id, e.id);
          check("res_width", result_width, e.w);
          check("res_timeout", result_timeout, e.to);
          check("res_latency", cyc, e.due);
          h_id = e.id;
          h_w = e.w;
          h_to = e.to;
        end
      end else check("res_hold", {result_id, result_timeout, result_width}, {h_id[1:0], h_to, h_w[CW-1:0]});
      for (int k = 0; k < N; k++)
        if (noise[k]) echo[k] = 1'($urandom);
        else if (stuck[k]) echo[k] = 1'b1;
        else if (dly[k] > 0) begin echo[k] = 1'b0; dly[k]--; end
        else if (hi[k] > 0) begin echo[k] = 1'b1; hi[k]--; end
        else echo[k] = 1'b0;
      prev_trig = trig;
      prev_mask = sensor_mask;
      prev_en = enable;
    end
  end

  task automatic wait_results(int n);
    int target = res_cnt + n, t = 0;
    while (res_cnt < target && t < 5000) begin @(negedge clk); t++; end
    check("wait_results", res_cnt >= target, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_trig(logic [N-1:0] v);
    int t = 0;
    while (trig !== v && t < 3000) begin @(negedge clk); t++; end
    check("wait_trig", trig, v);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_id", result_id, 0);
    check("rst_width", result_width, 0);
    check("rst_timeout", result_timeout, 0);
    @(posedge clk); #1;
    reset = 1;
    enable = 1;
    repeat (30) @(negedge clk);
    check("idle_mask0_busy", busy, 0);
    @(posedge clk); #1;
    sensor_mask = 4'b1111; mode = 2; fix_d = 3; fix_w = 30;
    wait_results(5);
    sensor_mask = 4'b0101; mode = 1;
    wait_results(3);
    sensor_mask = 4'b0010; stuck = 4'b0010;
    wait_results(2);
    stuck = '0; mode = 0; noise = 4'b0001;
    wait_results(4);
    noise = '0;
    for (int i = 0; i < 12; i++) begin
      sensor_mask = N'($urandom_range(1, 15));
      wait_results(1);
    end
    sensor_mask = 4'b0100; mode = 2; fix_d = 0; fix_w = 50;
    wait_trig(4'b0100);
    wait_trig(4'b0000);
    repeat (10) @(posedge clk);
    #1;
    check("measuring_ch2", echo[2], 1);
    enable = 0;
    wait_results(1);
    repeat (60) @(negedge clk);
    check("disabled_busy", busy, 0);
    check("disabled_trig", trig, 0);
    @(posedge clk); #1;
    sensor_mask = 4'b1111; mode = 0; rr_arm = 0; enable = 1;
    wait_trig(4'b1000);
    #2 reset = 0;
    q.delete();
    model_last = N - 1;
    for (int k = 0; k < N; k++) begin dly[k] = 0; hi[k] = 0; end
    h_id = 0; h_w = 0; h_to = 0;
    #1;
    check("midtrig_rst_trig", trig, 0);
    check("midtrig_rst_busy", busy, 0);
    check("midtrig_rst_valid", result_valid, 0);
    check("midtrig_rst_id", result_id, 0);
    check("midtrig_rst_width", result_width, 0);
    check("midtrig_rst_timeout", result_timeout, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rr_arm = 0;
    reset = 1;
    wait_results(1);
    enable = 0;
    for (int t = 0; t < 3000 && busy; t++) @(negedge clk);
    @(negedge clk);
    check("drain_idle", busy, 0);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/usensor_scheduler.md
USENSOR_SCHEDULER -- requirements
Module: usensor_scheduler

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 4, number of HC-SR04 channels (2..8).
REQ-002 SHALL have parameter TRIG_CYCLES, default 500, trig pulse width in clk cycles (10 us at 50 MHz).
REQ-003 SHALL have parameter ECHO_TIMEOUT, default 1900000, maximum wait or echo width in cycles (38 ms).
REQ-004 SHALL have parameter GUARD_CYCLES, default 3000000, inter-measurement quiet time in cycles (60 ms).
REQ-005 SHALL have parameter CNT_W, default 22, width of the cycle counters and result_width.
REQ-006 SHALL have port clk  input  1  single system clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port enable  input  1  allows new measurements to start.
REQ-009 SHALL have port sensor_mask  input  NUM_SENSORS  1 = channel participates in the round-robin.
REQ-010 SHALL have port echo  input  NUM_SENSORS  raw asynchronous echo pins.
REQ-011 SHALL have port trig  output  NUM_SENSORS  trig pins, at most one bit high at any time.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port result_valid  output  1  one-cycle pulse when a result is presented.
REQ-014 SHALL have port result_id  output  clog2(NUM_SENSORS)  channel of the result.
REQ-015 SHALL have port result_width  output  CNT_W  synchronized echo-high width in cycles.
REQ-016 SHALL have port result_timeout  output  1  result is a timeout, not a valid echo.

Function
REQ-017 SHALL pass echo through a 2-flop synchronizer; all echo references below mean the synchronized value.
REQ-018 SHALL implement states IDLE, TRIG, WAIT_RISE, MEASURE, GUARD.
REQ-019 IDLE: on enable=1 and sensor_mask!=0, SHALL select the next set mask bit after the last-served channel (wrapping), go to TRIG, and clear counters; it SHALL stay in IDLE if the mask is 0.
REQ-020 TRIG: trig[sel] SHALL be high for exactly TRIG_CYCLES consecutive cycles, then the block SHALL enter WAIT_RISE.
REQ-021 WAIT_RISE: echo[sel]=1 SHALL enter MEASURE with width counter=1; if ECHO_TIMEOUT cycles pass without a rise, it SHALL issue a result with timeout=1, width=0, then enter GUARD.
REQ-022 MEASURE: the width SHALL increment each cycle echo[sel]=1; on echo falling it SHALL issue the result with timeout=0; on width reaching ECHO_TIMEOUT it SHALL issue the result with timeout=1 and width=ECHO_TIMEOUT (saturated), then enter GUARD.
REQ-023 A result SHALL appear with result_valid on the cycle after the terminating condition; id, width and timeout SHALL hold until the next result.
REQ-024 GUARD: the block SHALL wait GUARD_CYCLES cycles with all trig low, then go to IDLE and record sel as last-served.
REQ-025 Deasserting enable mid-measurement SHALL NOT abort it; the sequence SHALL complete through GUARD and then remain in IDLE.
REQ-026 sensor_mask changes SHALL take effect only at the next IDLE selection; clearing the active channel's bit mid-measurement SHALL NOT abort it.
REQ-027 Echo activity on unselected channels SHALL be ignored.
REQ-028 After reset, the first selection SHALL start its search from channel 0 (last-served = NUM_SENSORS-1).

Reset
REQ-029 On reset=0, the block SHALL asynchronously force state=IDLE, trig=0, busy=0, result_valid=0, result_id=0, result_width=0, result_timeout=0, counters=0, synchronizer flops=0, last-served=NUM_SENSORS-1.
REQ-030 A reset asserted mid-TRIG SHALL drop trig in the same cycle, without waiting for a clock edge.

Structure
REQ-031 Package usensor_pkg SHALL hold the state enum and the default timing constants (TRIG_CYCLES, ECHO_TIMEOUT, GUARD_CYCLES).
REQ-032 Sub-module usensor_sync SHALL implement the parameterized-width 2-flop echo synchronizer.

Verification (N=4, TRIG_CYCLES=5, ECHO_TIMEOUT=100, GUARD_CYCLES=20)
REQ-033 mask=4'b1111, enable=1, each echo high 30 cycles after trig -> results for ids 0,1,2,3,0 in order, width=30, timeout=0, trig pulses exactly 5 cycles.
REQ-034 mask=4'b0101, no echo -> ids alternate 2,0,2, each timeout=1, width=0, valid 100 cycles after trig falls.
REQ-035 echo[1] stuck high -> result id 1, width=100, timeout=1; next trig begins 20 guard cycles later.
REQ-036 enable drops during MEASURE of channel 2 -> result for channel 2 is delivered, GUARD completes, IDLE held, busy=0, no further trig.
REQ-037 reset low during TRIG of channel 3 -> trig=0 immediately, all outputs 0; after release, the first trig goes to channel 0.
REQ-038 echo[0] toggles while channel 1 is being measured -> channel 1 result is unaffected and no trig[0] fires out of order.
